// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-way round-robin
// arbiter that drives a shared 4-to-1 mux.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot_idx(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// W-bit 4-to-1 multiplexer; {S1,S0} selects I0..I3.
module mux4_w
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic         S0,
  input  logic         S1,
  output logic [W-1:0] Y
);

  logic [SEL_W-1:0] w_s;

  assign w_s = {S1, S0};

  always_comb begin
    case (w_s)
      2'd0:    Y = I0;
      2'd1:    Y = I1;
      2'd2:    Y = I2;
      default: Y = I3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters, with a
// hold limit that preempts the owner while others wait.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     in0,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  input  logic [W-1:0]     in3,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y,
  output logic             y_valid,
  output logic             busy
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [7:0]       r_hold;

  state_t           w_state_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [7:0]       w_hold_nxt;

  logic             w_found;
  logic [SEL_W-1:0] w_winner;
  logic             w_others;
  logic             w_release;

  // Scan from ptr upward with 2-bit wrap; first asserted request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[r_ptr + SEL_W'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + SEL_W'(k);
      end
    end
  end

  // Owner drop and preempt can coincide; either way it is one release.
  assign w_others  = (req & ~r_grant) != '0;
  assign w_release = !req[r_sel] || ((r_hold == HOLD_LAST) && w_others);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = onehot_idx(w_winner);
          w_sel_nxt   = w_winner;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel + 1'b1;
        end else if (r_hold != HOLD_LAST) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign y_valid = |r_grant;
  assign busy    = (r_state == ST_GRANT);

  mux4_w #(.W(W)) u_mux (
    .I0(in0),
    .I1(in1),
    .I2(in2),
    .I3(in3),
    .S0(r_sel[0]),
    .S1(r_sel[1]),
    .Y (y)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic checked
// against a cycle-level ownership model.
module tb_mux4_rr_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] in_d [4];
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         y_valid;
  logic         busy;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .in0    (in_d[0]),
    .in1    (in_d[1]),
    .in2    (in_d[2]),
    .in3    (in_d[3]),
    .grant  (grant),
    .sel    (sel),
    .y      (y),
    .y_valid(y_valid),
    .busy   (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who owns the mux, for how many cycles, and whose turn is next
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_held;

  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_held  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    bit found;
    bit waiting;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          found   = 1;
          m_owner = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        m_sel  = m_owner;
        m_held = 1;
      end
    end else begin
      waiting = (r & ~(4'b0001 << m_owner)) != 4'b0000;
      if (!r[m_owner] || (m_held >= MAX_HOLD && waiting)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [3:0] model_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  task automatic check_outputs();
    chk("grant", 32'(grant), 32'(model_grant()));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("y_valid", 32'(y_valid), 32'(m_owner >= 0));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("y", 32'(y), 32'(in_d[m_sel]));
  endtask

  // driver: called at a negedge, applies req for the coming posedge
  task automatic step(input logic [3:0] r);
    req = r;
    for (int i = 0; i < 4; i++) in_d[i] = W'($urandom);
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(y_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] prev_grant;
    int         cnt;

    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) in_d[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_grant", 32'(grant), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // reset mid-grant, then grant resumes one edge after deassert
    step(4'b0010);
    step(4'b0010);
    do_reset();
    step(4'b0010);
    chk("rst_regrant", 32'(grant), 32'h2);
    step(4'b0000);

    // sole requester holds indefinitely
    step(4'b0100);
    chk("sp_grant", 32'(grant), 32'h4);
    chk("sp_sel", 32'(sel), 32'h2);
    chk("sp_y", 32'(y), 32'(in_d[2]));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0100);
      if (grant == 4'b0100) cnt++;
    end
    chk("sp_hold_cycles", 32'(cnt), 32'd20);
    step(4'b0000);

    // ptr = 3 wraps to requester 0; then ptr = 1 skips 0
    step(4'b0001);
    chk("wrap_grant", 32'(grant), 32'h1);
    step(4'b0000);
    step(4'b1011);
    chk("skip_grant", 32'(grant), 32'h2);
    step(4'b0000);

    // round-robin order with each owner dropping after two cycles
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev_grant = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      step(r);
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (exp_q.size() > 0) chk("rr_order", 32'(grant), 32'(exp_q.pop_front()));
        else chk("rr_extra_grant", 32'(grant), 32'h0);
      end
      prev_grant = grant;
    end
    chk("rr_remaining", 32'(exp_q.size()), 32'd0);

    // preemption after MAX_HOLD cycles
    do_reset();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0011);
      if (grant == 4'b0001) cnt++;
    end
    chk("pre_len", 32'(cnt), 32'(MAX_HOLD));
    chk("pre_next", 32'(grant), 32'h2);

    // owner drop coincides with preempt point
    do_reset();
    repeat (4) step(4'b1010);
    chk("sim_hold", 32'(grant), 32'h2);
    step(4'b1000);
    chk("sim_release", 32'(grant), 32'h0);
    step(4'b1000);
    chk("sim_next", 32'(grant), 32'h8);

    // random traffic, sticky requests, occasional reset
    step(4'b0000);
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
